multicycle_main_fsm: RTL and testbench

Main control FSM for the multicycle ARM-subset core. It sequences fetch, decode, memory and ALU phases from the instruction's `Op`/`Funct`/`Rd` fields. It drives the datapath mux selects and enables, and feeds `PCS`, `RegW`, `MemW`, `NoWrite` and `FlagW` into the conditional-logic stage, which gates them with the condition check.

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/alu_decoder.sv | 45 ++++
 rtl/multicycle_main_fsm.sv | 152 +++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control path.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10
    } op_t;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the data-processing cmd/S fields onto ALU control, flag-write and
// no-write requests. Outputs are idle (ADD, no flags) when alu_op is low.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic       alu_op,
    input  logic [5:0] funct,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write
);

    logic [3:0] cmd;
    logic       s_bit;
    logic       arith;

    assign cmd   = funct[4:1];
    assign s_bit = funct[0];
    assign arith = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);

    // Decode cmd; unsupported commands run as ADD but never write a register.
    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        no_write    = 1'b0;
        if (alu_op) begin
            case (cmd)
                CMD_ADD: alu_control = ALU_ADD;
                CMD_SUB: alu_control = ALU_SUB;
                CMD_AND: alu_control = ALU_AND;
                CMD_ORR: alu_control = ALU_ORR;
                CMD_CMP: begin
                    alu_control = ALU_SUB;
                    no_write    = 1'b1;
                end
                default: begin
                    alu_control = ALU_ADD;
                    no_write    = 1'b1;
                end
            endcase
            flag_w = {s_bit, s_bit & arith};
        end
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle core: sequences fetch, decode, memory
// and ALU phases and drives datapath selects and unconditioned write requests.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4
// DECODE   | read registers, compute PC+8
// MEMADR   | compute load/store address
// MEMREAD  | read data memory
// MEMWB    | write loaded word to Rd
// MEMWRITE | write data memory
// EXECUTER | ALU op with register operand
// EXECUTEI | ALU op with immediate operand
// ALUWB    | write ALU result to Rd
// BRANCH   | compute branch target and load PC
module multicycle_main_fsm
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         FlagW,
    output logic               RegW,
    output logic               MemW,
    output logic               PCS,
    output logic               NoWrite,
    output logic               Branch,
    output logic [STATE_W-1:0] State
);

    state_t     state_q;
    state_t     state_d;
    logic       alu_op;
    logic [1:0] dec_alu_control;
    logic [1:0] dec_flag_w;
    logic       dec_no_write;
    logic       ir_write_raw;
    logic       next_pc_raw;
    logic       reg_w_raw;
    logic       mem_w_raw;
    logic       branch_raw;

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and per-state datapath controls; illegal codes fall to FETCH.
    always_comb begin
        state_d      = S_FETCH;
        ir_write_raw = 1'b0;
        next_pc_raw  = 1'b0;
        reg_w_raw    = 1'b0;
        mem_w_raw    = 1'b0;
        branch_raw   = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_REG;
        alu_op       = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d      = S_DECODE;
                ir_write_raw = 1'b1;
                next_pc_raw  = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                if (Op == OP_MEM)     state_d = S_MEMADR;
                else if (Op == OP_DP) state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                else if (Op == OP_BR) state_d = S_BRANCH;
                else                  state_d = S_FETCH;
            end
            S_MEMADR: begin
                state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                state_d = S_MEMWB;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                reg_w_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_w_raw = 1'b1;
            end
            S_EXECUTER: begin
                state_d = S_ALUWB;
                alu_op  = 1'b1;
            end
            S_EXECUTEI: begin
                state_d = S_ALUWB;
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
            end
            S_ALUWB: begin
                reg_w_raw = 1'b1;
                alu_op    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURES;
                branch_raw = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALUWB keeps the decoder running so NoWrite/FlagW stay valid for the
    // write-back gating; Funct is held by the IR across both cycles.
    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (dec_alu_control),
        .flag_w      (dec_flag_w),
        .no_write    (dec_no_write)
    );

    // Write requests are masked while reset is held so nothing leaks out.
    always_comb begin
        ALUControl = (state_q == S_ALUWB) ? ALU_ADD : dec_alu_control;
        FlagW      = dec_flag_w & {2{reset}};
        NoWrite    = dec_no_write & reset;
        IRWrite    = ir_write_raw & reset;
        NextPC     = next_pc_raw & reset;
        RegW       = reg_w_raw & reset;
        MemW       = mem_w_raw & reset;
        Branch     = branch_raw & reset;
        PCS        = ((reg_w_raw & (Rd == 4'd15)) | branch_raw) & reset;
        State      = STATE_W'(state_q);
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm with an instruction-level model.
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic [3:0] Rd = 4'd0;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, PCS, NoWrite, Branch;
    logic [1:0] ResultSrc, ALUSrcB, ALUControl, FlagW;
    logic [3:0] State;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;
    int exp_q[$];
    logic [3:0]  obs_st [0:15];
    logic [16:0] obs_v  [0:15];

    // {IRWrite,NextPC,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,FlagW,RegW,MemW,PCS,NoWrite,Branch}
    localparam logic [16:0] RST_VEC = 17'b0_0_0_10_1_10_00_00_0_0_0_0_0;

    multicycle_main_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .FlagW(FlagW),
        .RegW(RegW), .MemW(MemW), .PCS(PCS), .NoWrite(NoWrite), .Branch(Branch),
        .State(State)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] dut_vec();
        return {IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
                FlagW, RegW, MemW, PCS, NoWrite, Branch};
    endfunction

    // Expected control word for a phase of the current instruction.
    function automatic logic [16:0] exp_vec(int st, logic [5:0] f, logic [3:0] rd);
        logic [3:0] cmd;
        logic       s, ir, npc, adr, srca, regw, memw, br, nw, pcs, known, arith;
        logic [1:0] res, srcb, alu, fw, ctrl;
        cmd = f[4:1];
        s   = f[0];
        ir = 0; npc = 0; adr = 0; srca = 0; regw = 0; memw = 0; br = 0; nw = 0;
        res = 2'b00; srcb = 2'b00; alu = 2'b00; fw = 2'b00;
        case (cmd)
            4'b0100: ctrl = 2'b00;
            4'b0010: ctrl = 2'b01;
            4'b0000: ctrl = 2'b10;
            4'b1100: ctrl = 2'b11;
            4'b1010: ctrl = 2'b01;
            default: ctrl = 2'b00;
        endcase
        known = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) || (cmd == 4'b1100);
        arith = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
        case (st)
            0: begin ir = 1; npc = 1; srca = 1; srcb = 2'b10; res = 2'b10; end
            1: begin srca = 1; srcb = 2'b10; res = 2'b10; end
            2: srcb = 2'b01;
            3: adr = 1;
            4: begin res = 2'b01; regw = 1; end
            5: begin adr = 1; memw = 1; end
            6: begin alu = ctrl; fw = {s, s & arith}; nw = !known; end
            7: begin srcb = 2'b01; alu = ctrl; fw = {s, s & arith}; nw = !known; end
            8: begin regw = 1; fw = {s, s & arith}; nw = !known; end
            9: begin srcb = 2'b01; res = 2'b10; br = 1; end
            default: ;
        endcase
        pcs = (regw && rd == 4'd15) || br;
        return {ir, npc, adr, res, srca, srcb, alu, fw, regw, memw, pcs, nw, br};
    endfunction

    task automatic check_val(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle compare of the DUT against the expected phase sequence.
    always @(negedge clk) begin
        if (chk_on && exp_q.size() > 0) begin
            int es;
            logic [16:0] ev, av;
            es = exp_q.pop_front();
            ev = exp_vec(es, Funct, Rd);
            av = dut_vec();
            tests++;
            if (State !== 4'(es)) begin
                fails++;
                $display("FAIL state: got %0d, expected %0d", State, es);
            end
            tests++;
            if (av !== ev) begin
                fails++;
                $display("FAIL outputs in state %0d: got %b, expected %b", es, av, ev);
            end
        end
    end

    // Phases an instruction walks through, from its class alone.
    task automatic push_path(logic [1:0] op, logic [5:0] f);
        exp_q.push_back(0);
        exp_q.push_back(1);
        if (op == 2'b01) begin
            exp_q.push_back(2);
            if (f[0]) begin exp_q.push_back(3); exp_q.push_back(4); end
            else      exp_q.push_back(5);
        end else if (op == 2'b00) begin
            exp_q.push_back(f[5] ? 7 : 6);
            exp_q.push_back(8);
        end else if (op == 2'b10) begin
            exp_q.push_back(9);
        end
    endtask

    // Called just after a clock edge with the DUT in FETCH.
    task automatic run_instr(string name, logic [1:0] op, logic [5:0] f, logic [3:0] rd, int lat);
        int n;
        Op = op; Funct = f; Rd = rd;
        check_val({name, " start state"}, int'(State), 0);
        push_path(op, f);
        n = 0;
        obs_st[0] = State;
        obs_v[0]  = dut_vec();
        while (n < 15) begin
            @(posedge clk); #2;
            n++;
            if (State == 4'd0) break;
            obs_st[n] = State;
            obs_v[n]  = dut_vec();
        end
        check_val({name, " latency"}, n, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held for three cycles
        repeat (3) begin
            @(posedge clk); #2;
            check_val("reset state", int'(State), 0);
            check_val("reset outputs", int'(dut_vec()), int'(RST_VEC));
        end
        reset = 1'b1;
        #1;
        check_val("first IRWrite", int'(IRWrite), 1);
        check_val("first NextPC", int'(NextPC), 1);
        chk_on = 1'b1;

        run_instr("LDR", 2'b01, 6'b011001, 4'd3, 5);
        for (int i = 0; i < 5; i++) check_val("LDR seq", int'(obs_st[i]), i);
        check_val("LDR RegW s4", int'(obs_v[4][4]), 1);
        check_val("LDR ResultSrc s4", int'(obs_v[4][13:12]), 1);
        check_val("LDR PCS s4", int'(obs_v[4][2]), 0);
        for (int i = 0; i < 4; i++) check_val("LDR RegW early", int'(obs_v[i][4]), 0);

        run_instr("STR", 2'b01, 6'b011000, 4'd2, 4);
        check_val("STR s3", int'(obs_st[3]), 5);
        check_val("STR MemW", int'(obs_v[3][3]), 1);
        check_val("STR AdrSrc", int'(obs_v[3][14]), 1);
        check_val("STR MemW s2", int'(obs_v[2][3]), 0);

        run_instr("SUBS", 2'b00, 6'b000101, 4'd1, 4);
        check_val("SUBS s2", int'(obs_st[2]), 6);
        check_val("SUBS ALUControl", int'(obs_v[2][8:7]), 1);
        check_val("SUBS FlagW", int'(obs_v[2][6:5]), 3);
        check_val("SUBS NoWrite", int'(obs_v[2][1]), 0);

        run_instr("CMPI", 2'b00, 6'b110101, 4'd0, 4);
        check_val("CMPI s2", int'(obs_st[2]), 7);
        check_val("CMPI ALUControl", int'(obs_v[2][8:7]), 1);
        check_val("CMPI FlagW", int'(obs_v[2][6:5]), 3);
        check_val("CMPI NoWrite", int'(obs_v[2][1]), 1);

        run_instr("ADD R15", 2'b00, 6'b001000, 4'd15, 4);
        check_val("ADD R15 PCS", int'(obs_v[3][2]), 1);
        check_val("ADD R15 PCS exec", int'(obs_v[2][2]), 0);

        run_instr("ORR", 2'b00, 6'b011000, 4'd4, 4);
        check_val("ORR ALUControl", int'(obs_v[2][8:7]), 3);
        run_instr("ANDS", 2'b00, 6'b000001, 4'd5, 4);
        check_val("ANDS FlagW", int'(obs_v[2][6:5]), 2);
        run_instr("BADCMD", 2'b00, 6'b011110, 4'd6, 4);
        check_val("BADCMD NoWrite", int'(obs_v[3][1]), 1);

        run_instr("B", 2'b10, 6'b000000, 4'd0, 3);
        check_val("B s2", int'(obs_st[2]), 9);
        check_val("B Branch", int'(obs_v[2][0]), 1);
        check_val("B PCS", int'(obs_v[2][2]), 1);

        run_instr("UNDEF", 2'b11, 6'b000000, 4'd0, 2);
        check_val("UNDEF s1", int'(obs_st[1]), 1);

        // abort a load in MEMREAD with reset
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd3;
        push_path(2'b01, 6'b011001);
        repeat (3) begin @(posedge clk); #2; end
        check_val("abort pre state", int'(State), 3);
        chk_on = 1'b0;
        exp_q.delete();
        reset = 1'b0;
        #1;
        check_val("abort async state", int'(State), 0);
        check_val("abort RegW", int'(RegW), 0);
        repeat (2) begin
            @(posedge clk); #2;
            check_val("abort hold outputs", int'(dut_vec()), int'(RST_VEC));
        end
        reset = 1'b1;
        chk_on = 1'b1;
        run_instr("B after abort", 2'b10, 6'b000000, 4'd0, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
